fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory fetch bus between fetch unit and memory
interface fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with branch redirect, fault capture and retire counter
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    fetch_unit_if.master       bus,
    input  logic               i_retire,
    input  logic               i_taken_branch,
    input  logic               i_is_jalr,
    input  logic [31:0]        i_target,
    output logic [31:0]        o_instr,
    output logic               o_instr_valid,
    output logic [31:0]        o_pc,
    output logic [31:0]        o_pc_plus4,
    output logic               o_fault,
    output logic [1:0]         o_fault_cause,
    output logic [31:0]        o_instret
);
    localparam int WW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {S_REQ, S_EXEC, S_HALT} state_t;

    state_t          r_state;
    logic [31:0]     r_pc;
    logic [31:0]     r_instr;
    logic            r_instr_valid;
    logic            r_fault;
    logic [1:0]      r_fault_cause;
    logic [31:0]     r_instret;
    logic [WW-1:0]   r_wait;
    logic [31:0]     w_pc_plus4;
    logic [31:0]     w_next_pc;

    // Request is decoded from state only; held low while reset is asserted
    assign bus.mem_req  = (r_state == S_REQ) && !rst;
    assign bus.mem_addr = r_pc;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_next_pc  = i_taken_branch ? (i_is_jalr ? {i_target[31:1], 1'b0} : i_target) : w_pc_plus4;

    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_pc          = r_pc;
    assign o_pc_plus4    = w_pc_plus4;
    assign o_fault       = r_fault;
    assign o_fault_cause = r_fault_cause;
    assign o_instret     = r_instret;

    // Fetch/execute/halt sequencing; HALT freezes everything until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_cause <= 2'd0;
            r_instret     <= '0;
            r_wait        <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (bus.mem_ack) begin
                        r_instr       <= bus.mem_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_EXEC;
                    end else if (r_wait == WW'(WAIT_LIMIT - 1)) begin
                        r_fault       <= 1'b1;
                        r_fault_cause <= 2'd2;
                        r_state       <= S_HALT;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (i_retire) begin
                        r_instr_valid <= 1'b0;
                        if (w_next_pc[1:0] != 2'b00) begin
                            r_fault       <= 1'b1;
                            r_fault_cause <= 2'd1;
                            r_state       <= S_HALT;
                        end else begin
                            r_pc      <= w_next_pc;
                            r_instret <= r_instret + 32'd1;
                            r_wait    <= '0;
                            r_state   <= S_REQ;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        retire, taken, jalr;
    logic [31:0] target;
    logic [31:0] instr, pc, pc_plus4, instret;
    logic        instr_valid, fault;
    logic [1:0]  fault_cause;
    int          n_cmp = 0;
    int          n_bad = 0;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000), .WAIT_LIMIT(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .i_retire(retire), .i_taken_branch(taken), .i_is_jalr(jalr), .i_target(target),
        .o_instr(instr), .o_instr_valid(instr_valid), .o_pc(pc), .o_pc_plus4(pc_plus4),
        .o_fault(fault), .o_fault_cause(fault_cause), .o_instret(instret)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] word);
        bus.mem_ack = 1'b1; bus.mem_rdata = word;
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic do_retire(input logic tk, input logic jr, input logic [31:0] tg);
        retire = 1'b1; taken = tk; jalr = jr; target = tg;
        tick();
        retire = 1'b0; taken = 1'b0; jalr = 1'b0; target = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        retire = 1'b1; taken = 1'b1; target = 32'h40;
        tick(); tick();
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc got=%h exp=0", pc); end
        n_cmp++; if (instret !== 32'h0) begin n_bad++; $display("FAIL rst_instret got=%h exp=0", instret); end
        n_cmp++; if (fault !== 1'b0 || fault_cause !== 2'd0) begin n_bad++; $display("FAIL rst_fault got=%b/%0d exp=0/0", fault, fault_cause); end
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; retire = 1'b0; taken = 1'b0; target = '0;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL rel_mem_req got=%b exp=1", bus.mem_req); end
        n_cmp++; if (bus.mem_addr !== 32'h0) begin n_bad++; $display("FAIL rel_mem_addr got=%h exp=0", bus.mem_addr); end
    endtask

    task automatic test_first_fetch;
        tick();
        n_cmp++; if (bus.mem_req !== 1'b1 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL ff_wait got=%b/%b exp=1/0", bus.mem_req, instr_valid); end
        do_fetch(32'h0000_0013);
        n_cmp++; if (instr !== 32'h13) begin n_bad++; $display("FAIL ff_instr got=%h exp=13", instr); end
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL ff_valid got=%b exp=1", instr_valid); end
        n_cmp++; if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin n_bad++; $display("FAIL ff_pc got=%h/%h exp=0/4", pc, pc_plus4); end
        n_cmp++; if (instret !== 32'h0) begin n_bad++; $display("FAIL ff_instret got=%h exp=0", instret); end
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL ff_mem_req got=%b exp=0", bus.mem_req); end
    endtask

    task automatic test_jump;
        do_retire(1'b1, 1'b0, 32'h100);
        n_cmp++; if (pc !== 32'h100 || bus.mem_addr !== 32'h100) begin n_bad++; $display("FAIL jal_pc got=%h/%h exp=100/100", pc, bus.mem_addr); end
        n_cmp++; if (instret !== 32'd1 || instr_valid !== 1'b0 || bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL jal_state got=%h/%b/%b exp=1/0/1", instret, instr_valid, bus.mem_req); end
        do_fetch(32'h0000_0093);
    endtask

    task automatic test_sequential;
        do_retire(1'b0, 1'b0, 32'h0);
        n_cmp++; if (pc !== 32'h104 || bus.mem_addr !== 32'h104) begin n_bad++; $display("FAIL seq_pc got=%h/%h exp=104/104", pc, bus.mem_addr); end
        n_cmp++; if (instret !== 32'd2 || bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL seq_instret got=%h/%b exp=2/1", instret, bus.mem_req); end
        do_fetch(32'h13);
        do_retire(1'b1, 1'b0, 32'h100);
        do_fetch(32'h13);
    endtask

    task automatic test_jalr;
        do_retire(1'b1, 1'b1, 32'h201);
        n_cmp++; if (pc !== 32'h200 || pc_plus4 !== 32'h204) begin n_bad++; $display("FAIL jalr_pc got=%h/%h exp=200/204", pc, pc_plus4); end
        n_cmp++; if (fault !== 1'b0 || instret !== 32'd4 || bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL jalr_state got=%b/%h/%b exp=0/4/1", fault, instret, bus.mem_req); end
        do_fetch(32'h0000_00AB);
    endtask

    task automatic test_ignored;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        n_cmp++; if (instr !== 32'hAB || pc !== 32'h200 || instr_valid !== 1'b1) begin n_bad++; $display("FAIL ack_in_exec got=%h/%h/%b exp=ab/200/1", instr, pc, instr_valid); end
        do_retire(1'b0, 1'b0, 32'h0);
        retire = 1'b1; taken = 1'b1; target = 32'h300;
        tick();
        retire = 1'b0; taken = 1'b0; target = '0;
        n_cmp++; if (pc !== 32'h204 || instret !== 32'd5 || bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL retire_in_req got=%h/%h/%b exp=204/5/1", pc, instret, bus.mem_req); end
        do_fetch(32'h55);
    endtask

    task automatic test_instret_wrap;
        force dut.r_instret = 32'hFFFF_FFFE;
        #1;
        release dut.r_instret;
        #1;
        n_cmp++; if (instret !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL wrap_preload got=%h exp=fffffffe", instret); end
        do_retire(1'b1, 1'b0, 32'h100);
        n_cmp++; if (instret !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_max got=%h exp=ffffffff", instret); end
        do_fetch(32'h13);
        do_retire(1'b1, 1'b0, 32'h100);
        n_cmp++; if (instret !== 32'h0 || pc !== 32'h100 || fault !== 1'b0) begin n_bad++; $display("FAIL wrap_zero got=%h/%h/%b exp=0/100/0", instret, pc, fault); end
        do_fetch(32'h77);
    endtask

    task automatic test_misaligned;
        do_retire(1'b1, 1'b0, 32'h102);
        n_cmp++; if (fault !== 1'b1 || fault_cause !== 2'd1) begin n_bad++; $display("FAIL mis_fault got=%b/%0d exp=1/1", fault, fault_cause); end
        n_cmp++; if (pc !== 32'h100 || instr_valid !== 1'b0 || bus.mem_req !== 1'b0 || instret !== 32'h0) begin n_bad++; $display("FAIL mis_state got=%h/%b/%b/%h exp=100/0/0/0", pc, instr_valid, bus.mem_req, instret); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D; retire = 1'b1;
        repeat (3) tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; retire = 1'b0;
        n_cmp++; if (pc !== 32'h100 || instret !== 32'h0 || instr !== 32'h77 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL halt_frozen got=%h/%h/%h/%b exp=100/0/77/0", pc, instret, instr, instr_valid); end
        n_cmp++; if (bus.mem_req !== 1'b0 || fault_cause !== 2'd1) begin n_bad++; $display("FAIL halt_req got=%b/%0d exp=0/1", bus.mem_req, fault_cause); end
    endtask

    task automatic test_timeout;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (fault !== 1'b0 || pc !== 32'h0 || bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL to_start got=%b/%h/%b exp=0/0/1", fault, pc, bus.mem_req); end
        repeat (15) tick();
        n_cmp++; if (bus.mem_req !== 1'b1 || fault !== 1'b0) begin n_bad++; $display("FAIL to_before got=%b/%b exp=1/0", bus.mem_req, fault); end
        tick();
        n_cmp++; if (fault !== 1'b1 || fault_cause !== 2'd2 || bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL to_fault got=%b/%0d/%b exp=1/2/0", fault, fault_cause, bus.mem_req); end
        rst = 1'b1;
        tick();
        n_cmp++; if (bus.mem_req !== 1'b0 || fault !== 1'b0 || fault_cause !== 2'd0 || pc !== 32'h0) begin n_bad++; $display("FAIL to_rst got=%b/%b/%0d/%h exp=0/0/0/0", bus.mem_req, fault, fault_cause, pc); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL to_rel got=%b exp=1", bus.mem_req); end
    endtask

    task automatic test_wait_boundary;
        repeat (15) tick();
        do_fetch(32'h1234_5673);
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5673 || fault !== 1'b0) begin n_bad++; $display("FAIL wb_accept got=%b/%h/%b exp=1/12345673/0", instr_valid, instr, fault); end
    endtask

    task automatic test_reset_mid_fetch;
        do_retire(1'b0, 1'b0, 32'h0);
        n_cmp++; if (pc !== 32'h4 || instret !== 32'd1) begin n_bad++; $display("FAIL rmf_pre got=%h/%h exp=4/1", pc, instret); end
        rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_0BAD;
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        n_cmp++; if (instr !== 32'h0 || instr_valid !== 1'b0 || pc !== 32'h0 || instret !== 32'h0) begin n_bad++; $display("FAIL rmf_discard got=%h/%b/%h/%h exp=0/0/0/0", instr, instr_valid, pc, instret); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL rmf_req got=%b exp=1", bus.mem_req); end
    endtask

    initial begin
        rst = 1'b1; retire = 1'b0; taken = 1'b0; jalr = 1'b0; target = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_first_fetch();
        test_jump();
        test_sequential();
        test_jalr();
        test_ignored();
        test_instret_wrap();
        test_misaligned();
        test_timeout();
        test_wait_boundary();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
